// File: rtl/spr_line_engine.sv
// Per-scanline sprite engine: loads up to NUM_SPR sprite records, then resolves the frontmost opaque pixel.
// Optional collision outputs enabled by defining SPR_COLLIDE_EN.
module spr_line_engine #(
    parameter int unsigned NUM_SPR = 8,
    parameter int unsigned X_WIDTH = 8,
    parameter int unsigned SPR_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           line_start,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [2*SPR_W+X_WIDTH+5-1:0]   load_data,
    input  logic                           load_done,
    input  logic                           pixel_valid,
    input  logic [X_WIDTH-1:0]             pixel_x,
    output logic [3:0]                     pal_colour,
    output logic                           spr_valid,
    output logic                           spr_priority,
`ifdef SPR_COLLIDE_EN
    output logic                           collide,
    output logic                           collide_sticky,
`endif
    output logic                           overflow
);

    localparam int unsigned CNT_W     = $clog2(NUM_SPR + 1);
    localparam int unsigned OFF_W     = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned XPOS_LSB  = 2 * SPR_W;
    localparam int unsigned PAL_LSB   = XPOS_LSB + X_WIDTH;
    localparam int unsigned PRI_BIT   = PAL_LSB + 2;
    localparam int unsigned HFLIP_BIT = PRI_BIT + 1;
    localparam int unsigned EN_BIT    = HFLIP_BIT + 1;
    localparam logic [X_WIDTH:0] SPR_W_EXT = (X_WIDTH + 1)'(SPR_W);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]   count;
    logic [NUM_SPR-1:0] slot_vld;
    logic [SPR_W-1:0]   slot_p0  [NUM_SPR];
    logic [SPR_W-1:0]   slot_p1  [NUM_SPR];
    logic [X_WIDTH-1:0] slot_x   [NUM_SPR];
    logic [1:0]         slot_pal [NUM_SPR];
    logic               slot_pri [NUM_SPR];
    logic               slot_en  [NUM_SPR];

    logic               accept;
    logic               room;
    logic [1:0]         pix [NUM_SPR];
    logic [NUM_SPR-1:0] opq;
    logic               win_any;
    logic [3:0]         win_colour;
    logic               win_pri;
    logic               show;

    function automatic logic [SPR_W-1:0] rev(input logic [SPR_W-1:0] v);
        logic [SPR_W-1:0] r;
        for (int i = 0; i < int'(SPR_W); i++) r[i] = v[int'(SPR_W) - 1 - i];
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; line_start dominates every state
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (line_start) next_state = S_LOAD;
            S_LOAD:   if (line_start) next_state = S_LOAD;
                      else if (load_done) next_state = S_ACTIVE;
            S_ACTIVE: if (line_start) next_state = S_LOAD;
            default:  next_state = S_IDLE;
        endcase
    end

    assign accept = load_valid & load_ready & ~line_start;
    assign room   = (count != CNT_W'(NUM_SPR));

    // Slot occupancy, count and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ready <= 1'b0;
            count      <= '0;
            slot_vld   <= '0;
            overflow   <= 1'b0;
        end else begin
            load_ready <= (next_state == S_LOAD);
            if (line_start) begin
                count    <= '0;
                slot_vld <= '0;
                overflow <= 1'b0;
            end else if (accept) begin
                if (room) begin
                    slot_vld[count] <= 1'b1;
                    count           <= count + CNT_W'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Record payload; hflip folded in here so lookup is always unflipped
    always_ff @(posedge clk) begin
        for (int s = 0; s < int'(NUM_SPR); s++) begin
            if (accept && room && count == CNT_W'(s)) begin
                slot_p0[s]  <= load_data[HFLIP_BIT] ? rev(load_data[SPR_W-1:0]) : load_data[SPR_W-1:0];
                slot_p1[s]  <= load_data[HFLIP_BIT] ? rev(load_data[2*SPR_W-1:SPR_W])
                                                    : load_data[2*SPR_W-1:SPR_W];
                slot_x[s]   <= load_data[XPOS_LSB +: X_WIDTH];
                slot_pal[s] <= load_data[PAL_LSB +: 2];
                slot_pri[s] <= load_data[PRI_BIT];
                slot_en[s]  <= load_data[EN_BIT];
            end
        end
    end

    for (genvar s = 0; s < NUM_SPR; s++) begin : g_slot
        logic [X_WIDTH:0] lo;
        logic [X_WIDTH:0] x_ext;
        logic [OFF_W-1:0] off;
        logic             hit;
        assign lo    = {1'b0, slot_x[s]};
        assign x_ext = {1'b0, pixel_x};
        assign off   = OFF_W'(pixel_x - slot_x[s]);
        assign hit   = slot_vld[s] & slot_en[s] & (x_ext >= lo) & (x_ext < lo + SPR_W_EXT);
        assign pix[s] = {slot_p1[s][off], slot_p0[s][off]};
        assign opq[s] = hit & (pix[s] != 2'b00);
    end

    // Lowest-index opaque slot wins
    always_comb begin
        win_any    = 1'b0;
        win_colour = 4'h0;
        win_pri    = 1'b0;
        for (int s = int'(NUM_SPR) - 1; s >= 0; s--) begin
            if (opq[s]) begin
                win_any    = 1'b1;
                win_colour = {slot_pal[s], pix[s]};
                win_pri    = slot_pri[s];
            end
        end
    end

    assign show = (state == S_ACTIVE) & ~line_start & pixel_valid & win_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_colour   <= 4'h0;
            spr_valid    <= 1'b0;
            spr_priority <= 1'b0;
        end else begin
            pal_colour   <= show ? win_colour : 4'h0;
            spr_valid    <= show;
            spr_priority <= show & win_pri;
        end
    end

`ifdef SPR_COLLIDE_EN
    logic [4:0] n_hit;
    logic       multi;

    always_comb begin
        n_hit = 5'd0;
        for (int s = 0; s < int'(NUM_SPR); s++) n_hit = n_hit + 5'(opq[s]);
    end

    assign multi = show & (n_hit >= 5'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collide        <= 1'b0;
            collide_sticky <= 1'b0;
        end else begin
            collide        <= multi;
            collide_sticky <= line_start ? 1'b0 : (collide_sticky | multi);
        end
    end
`endif

endmodule

// File: doc/spr_line_engine.md
Name: spr_line_engine

Overview:
- Parametrised successor to the single-sprite render buffer.
- Holds up to NUM_SPR sprite records for the current scanline and loads them through a valid/ready handshake during hblank.
- Per pixel, resolves the frontmost opaque sprite pixel and emits a registered 4-bit palette colour, a valid flag and a priority flag.
- Sits between the OAM/pattern fetch logic and the background/sprite colour multiplexer.

Parameters:
- NUM_SPR, 8: sprite slots per line; 1..16.
- X_WIDTH, 8: width of pixel_x and the sprite xpos field.
- SPR_W, 8: sprite width in pixels; the pattern is 2 bitplanes of SPR_W bits.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- line_start  in  1  one-cycle pulse; clears all slots and enters LOAD.
- load_valid  in  1  load_data is valid this cycle.
- load_ready  out  1  engine accepts load_data this cycle.
- load_data  in  2*SPR_W+X_WIDTH+5  sprite record. Fields, LSB first:
  - plane0 [SPR_W-1:0]
  - plane1 [2*SPR_W-1:SPR_W]
  - xpos [X_WIDTH bits]
  - pal [2 bits]
  - bkg_priority [1 bit]
  - hflip [1 bit]
  - enable [1 bit, MSB]
- load_done  in  1  pulse; LOAD -> ACTIVE.
- pixel_valid  in  1  pixel_x is a visible pixel this cycle.
- pixel_x  in  X_WIDTH  current pixel column.
- pal_colour  out  4  {pal, plane1 bit, plane0 bit} of the winning sprite.
- spr_valid  out  1  an opaque sprite pixel is present.
- spr_priority  out  1  bkg_priority bit of the winner.
- overflow  out  1  sticky per line; a record arrived while all slots were full.

Behaviour:
- Reset, asynchronous, any state:
  - state = IDLE.
  - All slot valid bits = 0; slot count = 0.
  - load_ready = 0, pal_colour = 0, spr_valid = 0, spr_priority = 0, overflow = 0.
- IDLE:
  - load_ready = 0; outputs held at 0.
  - line_start -> LOAD.
- LOAD:
  - On entry, slot valids cleared, count = 0, overflow = 0.
  - load_ready = 1.
  - On load_valid & load_ready:
    - If count < NUM_SPR: store the record in slot[count] and increment count.
    - If count == NUM_SPR: drop the record and set overflow. Loads are never back-pressured.
  - hflip is applied at store time: both planes are bit-reversed, so slot data is always in unflipped order.
  - Records with enable = 0 are stored but never match.
  - load_done -> ACTIVE; load_ready falls the next cycle.
  - If load_done and load_valid occur in the same cycle, the record is accepted first.
- ACTIVE:
  - load_ready = 0.
  - Each cycle with pixel_valid, every valid, enabled slot s tests the hit condition xpos_s <= pixel_x < xpos_s + SPR_W.
  - The sum xpos_s + SPR_W is computed X_WIDTH+1 bits wide: no wrap-around. A sprite at xpos 252 with SPR_W 8 covers columns 252..255 only.
  - Column offset = pixel_x - xpos_s, truncated to clog2(SPR_W) bits. Pixel bits are plane1[offset] and plane0[offset]. Offset 0 maps to bit 0 after the store-time flip.
  - A pixel is opaque when its 2-bit value is non-zero.
  - Winner: the lowest slot index with an opaque hit.
  - Outputs are registered with latency 1 cycle from pixel_x to pal_colour/spr_valid/spr_priority.
  - With no opaque hit, or pixel_valid = 0: spr_valid = 0, pal_colour = 0, spr_priority = 0.
  - line_start -> LOAD, same cycle priority over everything. The output register clears on the next edge.
- line_start in LOAD restarts LOAD: slots cleared, overflow cleared.
- overflow holds through ACTIVE until the next line_start or reset.
- Reset asserted mid-LOAD or mid-ACTIVE discards all slots; no partial record survives.

Optional Feature:
- SPR_COLLIDE_EN. When defined:
  - Adds output collide (1 bit), registered, same latency as spr_valid.
  - collide pulses 1 when two or more slots have opaque hits on the same pixel.
  - Adds output collide_sticky (1 bit), set by any collide, cleared by line_start or reset.
- When undefined, neither port exists and no collision logic is synthesised.

Test Plan:
- Reset/idle: assert rst_n = 0 mid-ACTIVE with a sprite hit in flight -> pal_colour = 0, spr_valid = 0, load_ready = 0 immediately. After release, no output until line_start.
- Single sprite: load xpos = 10, plane0 = 8'h81, plane1 = 8'h01, pal = 2'b10, hflip = 0, enable = 1; then load_done; sweep pixel_x 0..20:
  - pixel_x = 10 -> pal_colour = 4'hB one cycle later.
  - pixel_x = 17 -> pal_colour = 4'h9.
  - pixel_x 11..16 -> spr_valid = 0 (transparent).
  - pixel_x = 18 -> spr_valid = 0.
- Hflip: the same record with hflip = 1 -> pixel_x = 10 gives 4'h9, pixel_x = 17 gives 4'hB.
- Priority/overlap: slot0 xpos = 20 with all pixels value 01; slot1 xpos = 20 with all pixels value 11 -> pal_colour shows slot0's colour at every column 20..27. Slot0 pixel made transparent at column 22 -> column 22 shows slot1. With SPR_COLLIDE_EN: collide = 1 on columns 20..27 except 22.
- Edge/overflow: load NUM_SPR+1 = 9 records during one LOAD -> all 9 accepted with load_ready high, overflow = 1, the 9th never drawn. A sprite at xpos = 252 -> hits at 252..255 only, nothing at pixel_x 0..3. Next line_start -> overflow = 0.
- Back-to-back: load_valid and load_done in the same cycle -> record stored. A line_start during ACTIVE -> next cycle outputs 0 and load_ready = 1.
